// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neuron datapath (MAC stage and sigmoid stage).
// Signed Q(32-F).F activation format, saturation limits and the MAC FSM state encoding.
package nn_fixed_pkg;

  localparam int unsigned Q_W           = 32;
  localparam int unsigned FRAC_BITS_DEF = 16;
  localparam int unsigned PROD_W        = 2 * Q_W;

  typedef logic signed [Q_W-1:0] q_t;

  localparam q_t Q_MAX = 32'sh7FFF_FFFF;
  localparam q_t Q_MIN = 32'sh8000_0000;

  // Activation-format constants at the default fraction width, shared with the sigmoid stage
  localparam q_t Q_ONE       = 32'sh0001_0000;
  localparam q_t Q_HALF      = 32'sh0000_8000;
  localparam q_t Q_SIG_CLAMP = 32'sh0008_0000;

  typedef struct packed {
    q_t x;
    q_t w;
  } mac_pair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_SCALE,
    ST_OUT
  } mac_state_e;

  // Accumulator width with enough headroom that bias + N full-scale products cannot overflow
  function automatic int unsigned acc_width(input int unsigned n_inputs);
    return PROD_W + $clog2(n_inputs + 1);
  endfunction

endpackage

// File: rtl/nn_sat_shift.sv
// Combinational rescale of a wide Q.2F accumulator to 32-bit Q.F with saturation.
// Optional round-half-up before the shift when ROUND_EN is set; otherwise floor.
module nn_sat_shift
  import nn_fixed_pkg::*;
#(
  parameter int unsigned IN_W      = 68,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter bit          ROUND_EN  = 1'b0
) (
  input  logic signed [IN_W-1:0] acc,
  output q_t                     res_c,
  output logic                   sat_c
);

  localparam int unsigned EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] RND_ADD =
    ROUND_EN ? (EXT_W'(1) << (FRAC_BITS - 1)) : '0;
  localparam logic signed [EXT_W-1:0] LIM_HI = EXT_W'(Q_MAX);
  localparam logic signed [EXT_W-1:0] LIM_LO = EXT_W'(Q_MIN);

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] shr;

  // One extra bit keeps the rounding add from wrapping at the accumulator extremes
  always_comb begin
    ext   = EXT_W'(acc) + RND_ADD;
    shr   = ext >>> FRAC_BITS;
    res_c = shr[Q_W-1:0];
    sat_c = 1'b0;
    if (shr > LIM_HI) begin
      res_c = Q_MAX;
      sat_c = 1'b1;
    end else if (shr < LIM_LO) begin
      res_c = Q_MIN;
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_acc.sv
// Neuron MAC: bias + sum(x*w) over a valid/ready stream, rescaled to saturated Q.F.
// Build option: NEURON_MAC_ROUND_NEAREST_EN selects round-half-up instead of floor.
module neuron_mac_acc
  import nn_fixed_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] acc_out,
  output logic        sat,
  output logic        busy
);

  localparam int unsigned ACC_W = acc_width(N_INPUTS);
  localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

`ifdef NEURON_MAC_ROUND_NEAREST_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  mac_state_e state, state_nxt;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  bias_al_c;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [PROD_W-1:0] prod_c;
  logic                     prod_v;
  logic [CNT_W-1:0]         cnt;
  mac_pair_t                pair_c;
  logic                     hs_c;
  logic                     last_c;
  logic                     load_c;
  q_t                       res_c;
  logic                     sat_c;

  assign pair_c    = {x_in, w_in};
  assign prod_c    = PROD_W'(pair_c.x) * PROD_W'(pair_c.w);
  assign bias_al_c = ACC_W'(q_t'(bias)) <<< FRAC_BITS;
  assign hs_c      = in_valid & in_ready & ~clear;
  assign last_c    = (cnt == CNT_W'(N_INPUTS - 1));
  assign load_c    = (state == ST_IDLE) & start & ~clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // clear wins over every other input in the same cycle
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) state_nxt = ST_ACC;
        ST_ACC:   if (hs_c && last_c) state_nxt = ST_DRAIN;
        ST_DRAIN: state_nxt = ST_SCALE;
        ST_SCALE: state_nxt = ST_OUT;
        ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_OUT);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Product is registered; the accumulate trails the handshake by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_r <= '0;
      prod_v <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      prod_v <= hs_c;
      if (hs_c) begin
        prod_r <= prod_c;
        cnt    <= cnt + CNT_W'(1);
      end
      if (load_c) begin
        acc <= bias_al_c;
        cnt <= '0;
      end else if (prod_v) begin
        acc <= acc + ACC_W'(prod_r);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_out <= '0;
      sat     <= 1'b0;
    end else if (clear) begin
      acc_out <= '0;
      sat     <= 1'b0;
    end else if (state == ST_SCALE) begin
      acc_out <= res_c;
      sat     <= sat_c;
    end
  end

  nn_sat_shift #(
    .IN_W      (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .ROUND_EN  (ROUND_EN)
  ) u_sat_shift (
    .acc   (acc),
    .res_c (res_c),
    .sat_c (sat_c)
  );

endmodule
